// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: turns a DMA job into bursts that never cross 4 KiB,
// with a cap on issued-but-uncompleted bursts and a sticky abort.
module dma_burst_sequencer #(
    parameter int ADDR_W    = 25,
    parameter int CNT_W     = 16,
    parameter int MAX_LINES = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [CNT_W-1:0]  sector_cnt,
    input  logic              dma_type,
    input  logic              dma_start,
    input  logic              dma_abort,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              dma_aborted,
    output logic              cmd_val,
    input  logic              cmd_ack,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [5:0]        cmd_len,
    output logic              cmd_type,
    input  logic              cpl
);
    localparam int LW = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LW-1:0]     left_q, left_d;
    logic [3:0]        outst_q, outst_d;
    logic              abort_q, abort_d, type_q, type_d, pend_q, pend_d;
    logic [5:0]        room, blen;
    logic              hs;

    // room is the number of lines left before the next 4 KiB (32-line) boundary
    assign room        = 6'd32 - {1'b0, addr_q[4:0]};
    assign blen        = (room < 6'(MAX_LINES)) ? room : 6'(MAX_LINES);
    assign cmd_len     = (left_q < LW'(blen)) ? left_q[5:0] : blen;
    assign cmd_addr    = addr_q;
    assign cmd_type    = type_q;
    // pend_q keeps a presented command valid until acked, even after abort
    assign cmd_val     = (state_q == ISSUE) & (pend_q | ((outst_q < 4'(MAX_OUTST)) & ~abort_q));
    assign hs          = cmd_val & cmd_ack;
    assign dma_busy    = state_q != IDLE;
    assign dma_done    = state_q == DONE;
    assign dma_aborted = dma_done & abort_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        type_d  = type_q;
        abort_d = abort_q | (dma_abort & (state_q != IDLE));
        pend_d  = cmd_val & ~cmd_ack;
        outst_d = outst_q + {3'b0, hs} - {3'b0, cpl & (hs | (outst_q != 4'd0))};
        case (state_q)
            IDLE: if (dma_start) begin
                addr_d  = mem_address;
                type_d  = dma_type;
                left_d  = {sector_cnt, 2'b00};
                abort_d = 1'b0;
                state_d = (sector_cnt == '0) ? DONE : ISSUE;
            end
            ISSUE: if (hs) begin
                addr_d  = addr_q + ADDR_W'(cmd_len);
                left_d  = left_q - LW'(cmd_len);
                state_d = (left_d == '0) ? DRAIN : ISSUE;
            end else if (abort_q && !cmd_val) begin
                state_d = DRAIN;
            end
            DRAIN: state_d = (outst_d == 4'd0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            outst_q <= '0;
            abort_q <= 1'b0;
            type_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            outst_q <= outst_d;
            abort_q <= abort_d;
            type_q  <= type_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_dma_burst_sequencer.sv
// tb_dma_burst_sequencer: scenario tasks with a burst scoreboard for dma_burst_sequencer.
module tb_dma_burst_sequencer;
    localparam int ADDR_W = 25;
    localparam int CNT_W  = 16;

    typedef logic [ADDR_W+5:0] burst_t;

    logic              sclk = 1'b0;
    logic              rst  = 1'b1;
    logic [ADDR_W-1:0] mem_address = '0;
    logic [CNT_W-1:0]  sector_cnt = '0;
    logic              dma_type = 1'b0, dma_start = 1'b0, dma_abort = 1'b0;
    logic              cmd_ack = 1'b0, cpl = 1'b0;
    logic              dma_busy, dma_done, dma_aborted, cmd_val, cmd_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic [5:0]        cmd_len;

    burst_t exp_q[$];
    burst_t got[$];
    burst_t e, g;
    int n_checks = 0;
    int n_pass   = 0;

    dma_burst_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_LINES(8), .MAX_OUTST(4)) dut (
        .sclk(sclk), .rst(rst), .mem_address(mem_address), .sector_cnt(sector_cnt),
        .dma_type(dma_type), .dma_start(dma_start), .dma_abort(dma_abort),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_aborted(dma_aborted),
        .cmd_val(cmd_val), .cmd_ack(cmd_ack), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_type(cmd_type), .cpl(cpl)
    );

    always #5 sclk = ~sclk;

    // records every handshake that the next rising edge will complete
    always @(negedge sclk) if (!rst && cmd_val && cmd_ack) got.push_back({cmd_addr, cmd_len});

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n, input logic t);
        mem_address = a;
        sector_cnt  = n;
        dma_type    = t;
        dma_start   = 1'b1;
        tick();
        dma_start   = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({cmd_val, cmd_addr, cmd_len, cmd_type, dma_busy, dma_done, dma_aborted} !== '0)
            $display("FAIL reset_outputs: got val=%b addr=%h len=%0d type=%b busy=%b done=%b ab=%b want all 0",
                     cmd_val, cmd_addr, cmd_len, cmd_type, dma_busy, dma_done, dma_aborted);
        else n_pass++;
        #9 rst = 1'b0;
        tick();
    endtask

    task automatic test_split;
        cmd_ack = 1'b1;
        exp_q.push_back({25'h10, 6'd8});
        exp_q.push_back({25'h18, 6'd4});
        start_job(25'h10, 16'd3, 1'b1);
        n_checks++;
        if ({dma_busy, cmd_val, cmd_type} !== 3'b111)
            $display("FAIL split_cycle1: got busy/val/type=%b want 111", {dma_busy, cmd_val, cmd_type});
        else n_pass++;
        tick(); tick();
        n_checks++;
        if ({dma_busy, cmd_val} !== 2'b10)
            $display("FAIL split_drain: got busy/val=%b want 10", {dma_busy, cmd_val});
        else n_pass++;
        cpl = 1'b1;
        tick(); tick();
        cpl = 1'b0;
        n_checks++;
        if ({dma_done, dma_aborted} !== 2'b10)
            $display("FAIL split_done: got done/aborted=%b want 10", {dma_done, dma_aborted});
        else n_pass++;
        tick();
        n_checks++;
        if ({dma_busy, dma_done} !== 2'b00)
            $display("FAIL split_idle: got busy/done=%b want 00", {dma_busy, dma_done});
        else n_pass++;
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL split_count: got %0d bursts want %0d", got.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front(); g = got.pop_front(); n_checks++;
            if (g !== e) $display("FAIL split_burst: got addr=%h len=%0d want addr=%h len=%0d", g[ADDR_W+5:6], g[5:0], e[ADDR_W+5:6], e[5:0]);
            else n_pass++;
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_boundary;
        exp_q.push_back({25'h1E, 6'd2});
        exp_q.push_back({25'h20, 6'd6});
        start_job(25'h1E, 16'd2, 1'b0);
        n_checks++;
        if ({cmd_addr, cmd_len, cmd_type} !== {25'h1E, 6'd2, 1'b0})
            $display("FAIL boundary_first: got addr=%h len=%0d type=%b want 1e 2 0", cmd_addr, cmd_len, cmd_type);
        else n_pass++;
        tick(); tick();
        cpl = 1'b1;
        tick(); tick();
        cpl = 1'b0;
        n_checks++;
        if ({dma_done, dma_aborted} !== 2'b10)
            $display("FAIL boundary_done: got done/aborted=%b want 10", {dma_done, dma_aborted});
        else n_pass++;
        tick();
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL boundary_count: got %0d bursts want %0d", got.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front(); g = got.pop_front(); n_checks++;
            if (g !== e) $display("FAIL boundary_burst: got addr=%h len=%0d want addr=%h len=%0d", g[ADDR_W+5:6], g[5:0], e[ADDR_W+5:6], e[5:0]);
            else n_pass++;
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_outst_limit;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back({25'(i * 8), 6'd8});
        start_job(25'h0, 16'd16, 1'b0);
        tick(); tick(); tick(); tick();
        n_checks++;
        if (cmd_val !== 1'b0) $display("FAIL limit_full: got cmd_val=%b want 0", cmd_val);
        else n_pass++;
        tick();
        n_checks++;
        if (got.size() !== 4 || cmd_val !== 1'b0)
            $display("FAIL limit_hold: got %0d bursts val=%b want 4 bursts val=0", got.size(), cmd_val);
        else n_pass++;
        cpl = 1'b1;
        tick();
        cpl = 1'b0;
        n_checks++;
        if ({cmd_val, cmd_addr} !== {1'b1, 25'h20})
            $display("FAIL limit_reenable: got val=%b addr=%h want 1 20", cmd_val, cmd_addr);
        else n_pass++;
        tick();
        n_checks++;
        if (cmd_val !== 1'b0) $display("FAIL limit_one_more: got cmd_val=%b want 0", cmd_val);
        else n_pass++;
        cpl = 1'b1;
        tick();
        n_checks++;
        if (cmd_val !== 1'b1) $display("FAIL limit_cpl2: got cmd_val=%b want 1", cmd_val);
        else n_pass++;
        tick();
        cpl = 1'b0;
        n_checks++;
        if ({cmd_val, cmd_addr} !== {1'b1, 25'h30})
            $display("FAIL limit_cpl_with_hs: got val=%b addr=%h want 1 30", cmd_val, cmd_addr);
        else n_pass++;
        tick();
        n_checks++;
        if (cmd_val !== 1'b0) $display("FAIL limit_refull: got cmd_val=%b want 0", cmd_val);
        else n_pass++;
        for (int i = 0; i < 40 && !seen; i++) begin
            cpl = 1'b1;
            tick();
            seen = dma_done;
        end
        cpl = 1'b0;
        n_checks++;
        if (seen !== 1'b1 || dma_aborted !== 1'b0)
            $display("FAIL limit_done: got done=%b aborted=%b want 1 0", seen, dma_aborted);
        else n_pass++;
        tick();
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL limit_count: got %0d bursts want %0d", got.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front(); g = got.pop_front(); n_checks++;
            if (g !== e) $display("FAIL limit_burst: got addr=%h len=%0d want addr=%h len=%0d", g[ADDR_W+5:6], g[5:0], e[ADDR_W+5:6], e[5:0]);
            else n_pass++;
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_zero;
        start_job(25'h40, 16'd0, 1'b0);
        n_checks++;
        if ({dma_done, dma_busy, cmd_val, dma_aborted} !== 4'b1100)
            $display("FAIL zero_cycle1: got done/busy/val/ab=%b want 1100", {dma_done, dma_busy, cmd_val, dma_aborted});
        else n_pass++;
        tick();
        n_checks++;
        if ({dma_done, dma_busy} !== 2'b00)
            $display("FAIL zero_cycle2: got done/busy=%b want 00", {dma_done, dma_busy});
        else n_pass++;
        n_checks++;
        if (got.size() !== 0) $display("FAIL zero_bursts: got %0d bursts want 0", got.size());
        else n_pass++;
        got.delete();
    endtask

    task automatic test_abort;
        for (int i = 0; i < 3; i++) exp_q.push_back({25'(i * 8), 6'd8});
        start_job(25'h0, 16'd8, 1'b0);
        tick(); tick();
        cmd_ack   = 1'b0;
        dma_abort = 1'b1;
        tick();
        dma_abort = 1'b0;
        n_checks++;
        if ({cmd_val, cmd_addr, cmd_len} !== {1'b1, 25'h10, 6'd8})
            $display("FAIL abort_hold: got val=%b addr=%h len=%0d want 1 10 8", cmd_val, cmd_addr, cmd_len);
        else n_pass++;
        tick();
        n_checks++;
        if (cmd_val !== 1'b1) $display("FAIL abort_hold2: got cmd_val=%b want 1", cmd_val);
        else n_pass++;
        cmd_ack = 1'b1;
        tick();
        n_checks++;
        if ({cmd_val, dma_busy} !== 2'b01)
            $display("FAIL abort_stop: got val/busy=%b want 01", {cmd_val, dma_busy});
        else n_pass++;
        cpl = 1'b1;
        tick(); tick();
        n_checks++;
        if ({cmd_val, dma_done} !== 2'b00)
            $display("FAIL abort_drain: got val/done=%b want 00", {cmd_val, dma_done});
        else n_pass++;
        tick();
        cpl = 1'b0;
        n_checks++;
        if ({dma_done, dma_aborted} !== 2'b11)
            $display("FAIL abort_done: got done/aborted=%b want 11", {dma_done, dma_aborted});
        else n_pass++;
        tick();
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL abort_count: got %0d bursts want %0d", got.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front(); g = got.pop_front(); n_checks++;
            if (g !== e) $display("FAIL abort_burst: got addr=%h len=%0d want addr=%h len=%0d", g[ADDR_W+5:6], g[5:0], e[ADDR_W+5:6], e[5:0]);
            else n_pass++;
        end
        exp_q.delete(); got.delete();
    endtask

    task automatic test_async_reset;
        cmd_ack = 1'b0;
        start_job(25'h80, 16'd16, 1'b1);
        n_checks++;
        if (cmd_val !== 1'b1) $display("FAIL areset_pre: got cmd_val=%b want 1", cmd_val);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_val, dma_busy, cmd_type} !== 3'b000)
            $display("FAIL areset_now: got val/busy/type=%b want 000", {cmd_val, dma_busy, cmd_type});
        else n_pass++;
        rst = 1'b0;
        tick();
        cmd_ack = 1'b1;
        exp_q.push_back({25'h0, 6'd4});
        start_job(25'h0, 16'd1, 1'b0);
        tick();
        n_checks++;
        if ({cmd_val, dma_busy} !== 2'b01)
            $display("FAIL areset_drain: got val/busy=%b want 01", {cmd_val, dma_busy});
        else n_pass++;
        cpl = 1'b1;
        tick();
        cpl = 1'b0;
        n_checks++;
        if ({dma_done, dma_aborted} !== 2'b10)
            $display("FAIL areset_done: got done/aborted=%b want 10", {dma_done, dma_aborted});
        else n_pass++;
        tick();
        n_checks++;
        if (got.size() !== exp_q.size()) $display("FAIL areset_count: got %0d bursts want %0d", got.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front(); g = got.pop_front(); n_checks++;
            if (g !== e) $display("FAIL areset_burst: got addr=%h len=%0d want addr=%h len=%0d", g[ADDR_W+5:6], g[5:0], e[ADDR_W+5:6], e[5:0]);
            else n_pass++;
        end
        exp_q.delete(); got.delete();
    endtask

    initial begin
        test_reset();
        test_split();
        test_boundary();
        test_outst_limit();
        test_zero();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
